// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the SDRAM controller user interface; one transaction in flight at a time.
// All outputs registered; round-robin or fixed priority; a lost read return is recovered by a timeout.
module sdram_port_arbiter #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_rw,
    output logic [DATA_W-1:0] sd_wdata,
    output logic              sd_in_valid,
    input  logic              sd_busy,
    input  logic [DATA_W-1:0] sd_rdata,
    input  logic              sd_out_valid,
    output logic              grant_id,
    output logic              err_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WR_ACK, S_WAIT_RD} state_t;

    localparam logic [9:0] TMO = 10'(TIMEOUT);

    state_t              state_q, state_d;
    logic                prio_q, prio_d;     // port preferred on the next tie
    logic                grant_q, grant_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                in_valid_q, in_valid_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [9:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                win;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        grant_d    = grant_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        in_valid_d = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        win = req1_valid;
        if (req0_valid && req1_valid) begin
            win = (FIXED_PRIO != 0) ? 1'b0 : prio_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!sd_busy && (req0_valid || req1_valid)) begin
                    grant_d    = win;
                    prio_d     = ~win;
                    rw_d       = win ? req1_rw    : req0_rw;
                    addr_d     = win ? req1_addr  : req0_addr;
                    wdata_d    = win ? req1_wdata : req0_wdata;
                    in_valid_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = rw_q ? S_WR_ACK : S_WAIT_RD;
            end
            S_WR_ACK: begin
                ack0_d  = ~grant_q;
                ack1_d  = grant_q;
                state_d = S_IDLE;
            end
            S_WAIT_RD: begin
                // A timed-out read still completes, with zero data, so the requester never stalls.
                if (sd_out_valid || cnt_q == TMO) begin
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    state_d = S_IDLE;
                    if (!sd_out_valid) begin
                        err_d = 1'b1;
                    end
                    if (grant_q) begin
                        rdata1_d = sd_out_valid ? sd_rdata : '0;
                    end else begin
                        rdata0_d = sd_out_valid ? sd_rdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prio_q     <= 1'b0;
            grant_q    <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            in_valid_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            grant_q    <= grant_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            in_valid_q <= in_valid_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign req0_ack    = ack0_q;
    assign req0_rdata  = rdata0_q;
    assign req1_ack    = ack1_q;
    assign req1_rdata  = rdata1_q;
    assign sd_addr     = addr_q;
    assign sd_rw       = rw_q;
    assign sd_wdata    = wdata_q;
    assign sd_in_valid = in_valid_q;
    assign grant_id    = grant_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: timeline-based reference model checked every cycle plus directed literal checks.
module tb_sdram_port_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    rv, rw, ack;
    logic [AW-1:0] ra [2];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] rd [2];
    logic [AW-1:0] sd_addr;
    logic          sd_rw, sd_in_valid, sd_busy, sd_out_valid, grant_id, err_timeout;
    logic [DW-1:0] sd_wdata, sd_rdata;

    // fixed-priority instance, write-only traffic, controller never busy
    logic [1:0]    b_rv, b_ack;
    logic [DW-1:0] b_rd [2];
    logic [AW-1:0] b_sd_addr;
    logic          b_sd_rw, b_sd_in_valid, b_grant, b_err;
    logic [DW-1:0] b_sd_wdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req0_rw(rw[0]), .req0_addr(ra[0]), .req0_wdata(wd[0]),
        .req0_ack(ack[0]), .req0_rdata(rd[0]),
        .req1_valid(rv[1]), .req1_rw(rw[1]), .req1_addr(ra[1]), .req1_wdata(wd[1]),
        .req1_ack(ack[1]), .req1_rdata(rd[1]),
        .sd_addr(sd_addr), .sd_rw(sd_rw), .sd_wdata(sd_wdata), .sd_in_valid(sd_in_valid),
        .sd_busy(sd_busy), .sd_rdata(sd_rdata), .sd_out_valid(sd_out_valid),
        .grant_id(grant_id), .err_timeout(err_timeout)
    );

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(b_rv[0]), .req0_rw(1'b1), .req0_addr(23'h10), .req0_wdata(32'h1),
        .req0_ack(b_ack[0]), .req0_rdata(b_rd[0]),
        .req1_valid(b_rv[1]), .req1_rw(1'b1), .req1_addr(23'h20), .req1_wdata(32'h2),
        .req1_ack(b_ack[1]), .req1_rdata(b_rd[1]),
        .sd_addr(b_sd_addr), .sd_rw(b_sd_rw), .sd_wdata(b_sd_wdata), .sd_in_valid(b_sd_in_valid),
        .sd_busy(1'b0), .sd_rdata(32'h0), .sd_out_valid(1'b0),
        .grant_id(b_grant), .err_timeout(b_err)
    );

    // Reference model: tracks the transaction by its age in cycles since the grant decision.
    logic          started = 1'b0;
    int            cyc = 0, t_dec = 0, age;
    bit            act = 0, own = 0, orw = 0, pref = 0, w;
    logic          e_inv, e_grant, e_err, e_rw;
    logic [1:0]    e_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [DW-1:0] e_rd [2];

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        if (rst) begin
            act = 0; pref = 0;
            e_inv = 0; e_ack = 0; e_grant = 0; e_err = 0; e_rw = 0;
            e_addr = '0; e_wd = '0; e_rd[0] = '0; e_rd[1] = '0;
        end else begin
            e_inv = 0;
            e_ack = 0;
            if (!act) begin
                if (!sd_busy && rv != 2'b00) begin
                    w = (rv == 2'b11) ? pref : rv[1];
                    pref = !w; act = 1; own = w; orw = rw[w]; t_dec = cyc;
                    e_inv = 1; e_grant = w; e_addr = ra[w]; e_rw = rw[w]; e_wd = wd[w];
                end
            end else begin
                age = cyc - t_dec;
                if (orw) begin
                    if (age == 2) begin e_ack[own] = 1; act = 0; end
                end else if (age >= 2) begin
                    if (sd_out_valid) begin
                        e_ack[own] = 1; e_rd[own] = sd_rdata; act = 0;
                    end else if (age - 2 == TO) begin
                        e_ack[own] = 1; e_rd[own] = '0; e_err = 1; act = 0;
                    end
                end
            end
        end
    end

    task automatic cmp_cycle();
        tests++;
        if ({sd_in_valid, ack, grant_id, err_timeout, sd_rw} !== {e_inv, e_ack, e_grant, e_err, e_rw}
            || sd_addr !== e_addr || sd_wdata !== e_wd || rd[0] !== e_rd[0] || rd[1] !== e_rd[1]) begin
            fails++;
            $display("FAIL model t=%0t inv,ack,gnt,err,rw got %b want %b addr %h/%h wdata %h/%h rdata0 %h/%h rdata1 %h/%h",
                     $time, {sd_in_valid, ack, grant_id, err_timeout, sd_rw}, {e_inv, e_ack, e_grant, e_err, e_rw},
                     sd_addr, e_addr, sd_wdata, e_wd, rd[0], e_rd[0], rd[1], e_rd[1]);
        end
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    // Runs one request on port p; for reads the controller answers dly cycles after issue (dly<0: never).
    task automatic do_txn(input int p, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int dly, output int n_inv, output int n_ack, output logic g,
                          output logic [DW-1:0] r);
        int resp;
        resp = -1; n_inv = 0; n_ack = 0; g = 0; r = '0;
        @(negedge clk); #1;
        rv[p] = 1'b1; rw[p] = wr; ra[p] = a; wd[p] = d;
        for (int i = 1; i <= 200 && n_ack == 0; i++) begin
            @(negedge clk); #1;
            sd_out_valid = 1'b0;
            if (ack[p]) begin
                n_ack = i; r = rd[p]; rv[p] = 1'b0;
            end else begin
                if (sd_in_valid && n_inv == 0) begin n_inv = i; g = grant_id; resp = dly; end
                if (resp == 0) begin sd_out_valid = 1'b1; sd_rdata = d; resp = -1; end
                else if (resp > 0) resp--;
            end
        end
        if (n_ack == 0) begin
            rv[p] = 1'b0; tests++; fails++;
            $display("FAIL txn_ack_wait port %0d got no ack want ack within 200 cycles", p);
        end
    endtask

    initial begin
        int ni, na, k, seen;
        logic g;
        logic [DW-1:0] r;
        logic [3:0] gs;
        rv = 0; rw = 0; ra[0] = 0; ra[1] = 0; wd[0] = 0; wd[1] = 0;
        sd_busy = 0; sd_out_valid = 0; sd_rdata = 0; b_rv = 0;
        fork
            forever begin
                @(negedge clk);
                if (started) cmp_cycle();
            end
        join_none

        repeat (3) @(negedge clk);
        #1;
        check("reset in_valid", 64'(sd_in_valid), 0);
        check("reset acks", 64'(ack), 0);
        check("reset err", 64'(err_timeout), 0);
        rst = 0;

        // 1: port0 write
        do_txn(0, 1'b1, 23'h100, 32'hA5A5A5A5, 0, ni, na, g, r);
        check("wr inv cycle", 64'(ni), 1);
        check("wr ack cycle", 64'(na), 3);
        check("wr grant", 64'(g), 0);

        // 2: port1 read, return 6 cycles after issue
        do_txn(1, 1'b0, 23'h104, 32'h12345678, 6, ni, na, g, r);
        check("rd rdata", 64'(r), 64'h12345678);
        check("rd ack cycle", 64'(na), 8);
        check("rd grant", 64'(g), 1);

        // 3: both ports hold valid, round-robin alternates
        @(negedge clk); #1;
        rv = 2'b11; rw = 2'b11; ra[0] = 23'h1A0; ra[1] = 23'h1B0; wd[0] = 32'h11; wd[1] = 32'h22;
        k = 0; gs = 4'hF;
        for (int i = 0; i < 60 && k < 4; i++) begin
            @(negedge clk); #1;
            if (sd_in_valid) begin gs[k] = grant_id; k++; end
        end
        rv = 2'b00;
        check("rr count", 64'(k), 4);
        check("rr grants", 64'(gs), 64'hA);
        repeat (5) @(negedge clk);

        // 3b: fixed priority starves port1 until port0 drops
        #1; b_rv = 2'b11; k = 0; gs = 4'hF;
        for (int i = 0; i < 60 && k < 4; i++) begin
            @(negedge clk); #1;
            if (b_sd_in_valid) begin
                gs[k] = b_grant; k++;
                if (k == 3) b_rv[0] = 1'b0;
            end
        end
        b_rv = 2'b00;
        check("fp grants", 64'(gs), 64'h8);

        // 4: controller busy holds off the issue
        @(negedge clk); #1;
        sd_busy = 1; rv[0] = 1; rw[0] = 1; ra[0] = 23'h200; wd[0] = 32'h55;
        seen = 0;
        repeat (10) begin @(negedge clk); #1; seen += int'(sd_in_valid); end
        check("busy no issue", 64'(seen), 0);
        sd_busy = 0;
        @(negedge clk); #1;
        check("issue after busy", 64'(sd_in_valid), 1);
        check("busy addr", 64'(sd_addr), 64'h200);
        repeat (2) @(negedge clk);
        #1;
        check("busy ack", 64'(ack[0]), 1);
        rv[0] = 0;

        // 5: read with no return times out; a late return is ignored
        do_txn(0, 1'b0, 23'h300, 32'hDEADBEEF, -1, ni, na, g, r);
        check("tmo ack cycle", 64'(na), 23);
        check("tmo rdata", 64'(r), 0);
        check("tmo err", 64'(err_timeout), 1);
        sd_out_valid = 1; sd_rdata = 32'hBAD;
        @(negedge clk); #1;
        sd_out_valid = 0;
        seen = 0;
        repeat (4) begin @(negedge clk); #1; seen += int'(ack[0]) + int'(ack[1]); end
        check("stray no ack", 64'(seen), 0);
        check("err sticky", 64'(err_timeout), 1);

        // 6: reset while waiting for read data
        rv[0] = 1; rw[0] = 0; ra[0] = 23'h400;
        k = 0;
        for (int i = 0; i < 20 && k == 0; i++) begin @(negedge clk); #1; k = int'(sd_in_valid); end
        check("rst-case issued", 64'(k), 1);
        repeat (3) @(negedge clk);
        #1; rst = 1; rv[0] = 0;
        @(negedge clk); #1;
        check("rst outputs", 64'({sd_in_valid, ack, err_timeout, grant_id, sd_rw}), 0);
        check("rst addr", 64'(sd_addr), 0);
        check("rst rdata1", 64'(rd[1]), 0);
        rst = 0;
        do_txn(1, 1'b1, 23'h500, 32'h77, 0, ni, na, g, r);
        check("post-rst grant", 64'(g), 1);
        check("post-rst ack cycle", 64'(na), 3);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
